// File: rtl/keystep_if.sv
// Bus bundle for keystep_tuner: raw keys and direction in, tuning word,
// update strobe and debounced key state out.
interface keystep_if #(
    parameter int NKEYS = 3,
    parameter int WIDTH = 9
);
    logic [NKEYS-1:0] keyin;   // raw buttons, active low
    logic             dir;     // 0 = add step, 1 = subtract step
    logic [WIDTH-1:0] keyout;  // registered tuning word
    logic             upd;     // one-cycle pulse after keyout changed
    logic [NKEYS-1:0] held;    // debounced key state, 1 = pressed

    modport master (
        output keyin,
        output dir,
        input  keyout,
        input  upd,
        input  held
    );

    modport slave (
        input  keyin,
        input  dir,
        output keyout,
        output upd,
        output held
    );
endinterface

// File: rtl/keystep_tuner.sv
// keystep_tuner: multi-key debounced frequency-word tuner.
// Each accepted key press adds or subtracts that key's step to a WIDTH-bit
// tuning word, limited to [0, MAX_VAL] by saturation or modulo wrap.
// Optional feature macro: KEYSTEP_AUTOREPEAT_EN (held key auto-repeats).
module keystep_tuner #(
    parameter int                     NKEYS   = 3,
    parameter int                     WIDTH   = 9,
    parameter logic [NKEYS*WIDTH-1:0] STEPS   = {9'd100, 9'd10, 9'd1},
    parameter int                     MAX_VAL = 400,
    parameter bit                     WRAP    = 1'b0,
    parameter int                     DEB_CYC = 1_000_000
) (
    input  logic      clk,
    input  logic      rst,
    keystep_if.slave  bus
);
    localparam int               CW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0]    DEB_LAST = CW'(DEB_CYC - 1);
    localparam logic [WIDTH:0]   MAX_W    = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   ONE_W    = (WIDTH+1)'(1);

    logic [NKEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NKEYS-1:0] deb_q, deb_d;
    logic [CW-1:0]    cnt_q [NKEYS];
    logic [CW-1:0]    cnt_d [NKEYS];
    logic [NKEYS-1:0] ev_q, ev_d;
    logic [WIDTH-1:0] keyout_q, keyout_d;
    logic             chg_q, chg_d;
    logic             upd_q, upd_d;

    logic [NKEYS-1:0] rise_s, cand_s, rpt_s;
    logic [WIDTH:0]   step_s [NKEYS];
    logic [WIDTH:0]   step_sel_s, cur_s, sum_s, nxt_s;

    // Per-key step, folded into [0, MAX_VAL] at elaboration when wrapping.
    for (genvar k = 0; k < NKEYS; k++) begin : g_step
        localparam logic [WIDTH:0] RAW = {1'b0, STEPS[k*WIDTH +: WIDTH]};
        localparam logic [WIDTH:0] RED = WRAP ? (RAW % (MAX_W + ONE_W)) : RAW;
        assign step_s[k] = RED;
    end

    // Synchronise raw keys and run one stability counter per key.
    always_comb begin
        sync1_d = bus.keyin;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int k = 0; k < NKEYS; k++) begin
            if ((~sync2_q[k]) != deb_q[k]) begin
                if (cnt_q[k] == DEB_LAST) begin
                    deb_d[k] = ~deb_q[k];
                    cnt_d[k] = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end else begin
                cnt_d[k] = '0;
            end
        end
    end

`ifdef KEYSTEP_AUTOREPEAT_EN
    localparam int               RPT_DELAY  = 4 * DEB_CYC;
    localparam int               RPT_PERIOD = DEB_CYC;
    localparam int               RW         = $clog2(RPT_DELAY + 1);
    localparam logic [RW-1:0]    RPT_FIRST  = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0]    RPT_NEXT   = RW'(RPT_PERIOD - 1);

    logic [NKEYS-1:0] lh_s, lh_q, lh_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic             first_q, first_d;

    // Repeat timer for the lowest-index held key; restarts when that key changes.
    always_comb begin
        lh_s    = deb_d & (~deb_d + NKEYS'(1));
        lh_d    = lh_s;
        rpt_s   = '0;
        rcnt_d  = rcnt_q + RW'(1);
        first_d = first_q;
        if ((lh_s != lh_q) || (lh_s == '0)) begin
            rcnt_d  = '0;
            first_d = 1'b1;
        end else if (rcnt_q == (first_q ? RPT_FIRST : RPT_NEXT)) begin
            rpt_s   = lh_q;
            rcnt_d  = '0;
            first_d = 1'b0;
        end else begin
            rcnt_d  = rcnt_q + RW'(1);
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            lh_q    <= '0;
            rcnt_q  <= '0;
            first_q <= 1'b1;
        end else begin
            lh_q    <= lh_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
        end
    end
`else
    assign rpt_s = '0;
`endif

    // Pick one event per cycle: lowest-index press or repeat wins.
    always_comb begin
        rise_s = deb_d & ~deb_q;
        cand_s = rise_s | rpt_s;
        ev_d   = cand_s & (~cand_s + NKEYS'(1));
    end

    // Apply the selected step with saturate-or-wrap limiting.
    always_comb begin
        step_sel_s = '0;
        for (int k = 0; k < NKEYS; k++) begin
            step_sel_s = step_sel_s | (ev_q[k] ? step_s[k] : '0);
        end
        cur_s = {1'b0, keyout_q};
        sum_s = cur_s + step_sel_s;
        if (bus.dir == 1'b0) begin
            if (sum_s > MAX_W) begin
                nxt_s = WRAP ? (sum_s - MAX_W - ONE_W) : MAX_W;
            end else begin
                nxt_s = sum_s;
            end
        end else begin
            if (step_sel_s > cur_s) begin
                nxt_s = WRAP ? (cur_s + MAX_W + ONE_W - step_sel_s) : '0;
            end else begin
                nxt_s = cur_s - step_sel_s;
            end
        end
        if (ev_q != '0) begin
            keyout_d = nxt_s[WIDTH-1:0];
            chg_d    = (nxt_s[WIDTH-1:0] != keyout_q);
        end else begin
            keyout_d = keyout_q;
            chg_d    = 1'b0;
        end
        upd_d = chg_q;
    end

    // Main state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            deb_q    <= '0;
            for (int k = 0; k < NKEYS; k++) begin
                cnt_q[k] <= '0;
            end
            ev_q     <= '0;
            keyout_q <= '0;
            chg_q    <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            for (int k = 0; k < NKEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            ev_q     <= ev_d;
            keyout_q <= keyout_d;
            chg_q    <= chg_d;
            upd_q    <= upd_d;
        end
    end

    assign bus.keyout = keyout_q;
    assign bus.upd    = upd_q;
    assign bus.held   = deb_q;
endmodule
